// File: rtl/elevator_defs_pkg.sv
// Shared elevator definitions: floor and state encodings, call bit indices.
package elevator_defs_pkg;

  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned NUM_FLOORS = 3;

  // Floor encodings; 2'b11 never names a real floor.
  localparam logic [FLOOR_W-1:0] F1        = 2'b00;
  localparam logic [FLOOR_W-1:0] F2        = 2'b01;
  localparam logic [FLOOR_W-1:0] F3        = 2'b10;
  localparam logic [FLOOR_W-1:0] F_INVALID = 2'b11;

  // Bit positions of each floor in the call / call_led vectors.
  localparam int unsigned CALL_F1 = 0;
  localparam int unsigned CALL_F2 = 1;
  localparam int unsigned CALL_F3 = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRAVEL = 2'b01,
    ST_DOOR   = 2'b10
  } state_e;

  // One-hot call-vector mask for a floor; all zeros for the invalid code.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    oh = '0;
    case (f)
      F1:      oh[CALL_F1] = 1'b1;
      F2:      oh[CALL_F2] = 1'b1;
      F3:      oh[CALL_F3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/call_selector.sv
// Combinational SCAN target picker: keeps the sweep direction while work
// remains ahead of the car, otherwise reverses toward the nearest call behind.
module call_selector
  import elevator_defs_pkg::*;
(
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  input  logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    target,
  output logic                  target_valid,
  output logic                  new_dir_up
);

  logic                  w_up_found;
  logic                  w_dn_found;
  logic [FLOOR_W-1:0]    w_up_tgt;
  logic [FLOOR_W-1:0]    w_dn_tgt;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    w_up_found = 1'b0;
    w_dn_found = 1'b0;
    w_up_tgt   = cur_floor;
    w_dn_tgt   = cur_floor;
    if (cur_floor != F_INVALID) begin
      // Descending scan: the last hit above is the closest one.
      for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
        if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
          w_up_found = 1'b1;
          w_up_tgt   = FLOOR_W'(i);
        end
      end
      // Ascending scan: the last hit below is the closest one.
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
        if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
          w_dn_found = 1'b1;
          w_dn_tgt   = FLOOR_W'(i);
        end
      end
    end
  end

  // Direction-preserving choice between the two candidates.
  always_comb begin
    target       = cur_floor;
    target_valid = 1'b0;
    new_dir_up   = dir_up;
    if (dir_up && w_up_found) begin
      target       = w_up_tgt;
      target_valid = 1'b1;
      new_dir_up   = 1'b1;
    end else if (w_dn_found) begin
      target       = w_dn_tgt;
      target_valid = 1'b1;
      new_dir_up   = 1'b0;
    end else if (w_up_found) begin
      target       = w_up_tgt;
      target_valid = 1'b1;
      new_dir_up   = 1'b1;
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// Per-floor call scheduler for a 3-floor car: latches calls, issues goal
// floors to the movement datapath using SCAN order, and times the door dwell.
module call_scheduler
  import elevator_defs_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned TIMER_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  moving,
  output logic [FLOOR_W-1:0]    goal_floor,
  output logic [NUM_FLOORS-1:0] call_led,
  output logic                  door_open,
  output logic                  dir_up
);

  localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [FLOOR_W-1:0]    r_goal;
  logic [FLOOR_W-1:0]    w_goal_nxt;
  logic                  r_dir;
  logic                  w_dir_nxt;
  logic [TIMER_W-1:0]    r_timer;
  logic [TIMER_W-1:0]    w_timer_nxt;
  logic                  r_door;
  logic                  w_door_nxt;
  logic [NUM_FLOORS-1:0] r_call_led;
  logic [NUM_FLOORS-1:0] w_led_clr;

  logic [NUM_FLOORS-1:0] w_cur_oh;
  logic                  w_cur_valid;
  logic                  w_pend_here;
  logic                  w_call_here;
  logic                  w_arrived;
  logic                  w_retarget;
  logic [FLOOR_W-1:0]    w_sel_target;
  logic                  w_sel_valid;
  logic                  w_sel_dir;

  // Floor-match decode; an invalid cur_floor matches nothing.
  assign w_cur_oh    = floor_onehot(cur_floor);
  assign w_cur_valid = |w_cur_oh;
  assign w_pend_here = |(r_call_led & w_cur_oh);
  assign w_call_here = |(call & w_cur_oh);
  assign w_arrived   = (cur_floor == r_goal) && !moving;

  // F2 is the only floor that can lie between the car and its goal.
  assign w_retarget = r_call_led[CALL_F2] &&
                      (( r_dir && (cur_floor == F1) && (r_goal == F3)) ||
                       (!r_dir && (cur_floor == F3) && (r_goal == F1)));

  call_selector u_call_selector (
    .cur_floor    (cur_floor),
    .dir_up       (r_dir),
    .pending      (r_call_led),
    .target       (w_sel_target),
    .target_valid (w_sel_valid),
    .new_dir_up   (w_sel_dir)
  );

  // Next-state and next-output logic; everything holds while cur_floor is invalid.
  always_comb begin
    w_state_nxt = r_state;
    w_goal_nxt  = r_goal;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_door_nxt  = r_door;
    w_led_clr   = '0;
    if (w_cur_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_goal_nxt = cur_floor;
          if (w_pend_here) begin
            w_state_nxt = ST_DOOR;
            w_door_nxt  = 1'b1;
            w_timer_nxt = DWELL_LOAD;
            w_led_clr   = w_cur_oh;
          end else if (w_sel_valid) begin
            w_state_nxt = ST_TRAVEL;
            w_goal_nxt  = w_sel_target;
            w_dir_nxt   = w_sel_dir;
          end
        end
        ST_TRAVEL: begin
          if (w_arrived) begin
            w_state_nxt = ST_DOOR;
            w_door_nxt  = 1'b1;
            w_timer_nxt = DWELL_LOAD;
            w_led_clr   = w_cur_oh;
          end else if (w_retarget) begin
            w_goal_nxt = F2;
          end
        end
        ST_DOOR: begin
          // A call at the open floor is absorbed: it restarts the dwell instead of latching.
          w_led_clr = w_cur_oh;
          if (w_call_here) begin
            w_timer_nxt = DWELL_LOAD;
          end else if (r_timer == '0) begin
            w_state_nxt = ST_IDLE;
            w_door_nxt  = 1'b0;
          end else begin
            w_timer_nxt = r_timer - TIMER_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_door_nxt  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_goal  <= F1;
      r_dir   <= 1'b1;
      r_timer <= '0;
      r_door  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_goal  <= w_goal_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
      r_door  <= w_door_nxt;
    end
  end

  // Pending-call latch; a clear at the serviced floor beats a same-cycle call.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_call_led <= '0;
    end else begin
      r_call_led <= (r_call_led | call) & ~w_led_clr;
    end
  end

  assign goal_floor = r_goal;
  assign call_led   = r_call_led;
  assign door_open  = r_door;
  assign dir_up     = r_dir;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: a simple car model moves toward goal_floor, a SCAN
// reference queues the expected door-service order, a monitor checks each door.
module tb_call_scheduler;
  import elevator_defs_pkg::*;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] call;
  logic [1:0] cur_floor;
  logic       moving;
  logic [1:0] goal_floor;
  logic [2:0] call_led;
  logic       door_open;
  logic       dir_up;

  // Car model state (environment, not expectation).
  logic [1:0] car_pos = 2'b00;
  logic       force_invalid = 1'b0;
  int         step_len = 5;
  int         step_cnt = 5;

  // Scoreboard and reference-model state.
  logic [1:0] exp_floor_q[$];
  int         exp_dur_q[$];
  logic       m_dir;
  int         n_pass = 0;
  int         n_checks = 0;

  always #5 clk = ~clk;

  assign cur_floor = force_invalid ? 2'b11 : car_pos;
  assign moving    = (cur_floor != goal_floor);

  call_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .call       (call),
    .cur_floor  (cur_floor),
    .moving     (moving),
    .goal_floor (goal_floor),
    .call_led   (call_led),
    .door_open  (door_open),
    .dir_up     (dir_up)
  );

  // Car steps one floor toward goal every step_len cycles.
  always @(posedge clk) begin
    if (goal_floor != car_pos && goal_floor != 2'b11 && !force_invalid) begin
      if (step_cnt <= 1) begin
        car_pos  <= (goal_floor > car_pos) ? car_pos + 2'd1 : car_pos - 2'd1;
        step_cnt <= step_len;
      end else begin
        step_cnt <= step_cnt - 1;
      end
    end else begin
      step_cnt <= step_len;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // SCAN reference: serve the current floor, then sweep the current direction, then reverse.
  task automatic plan(input logic [2:0] mask, input int dur);
    int cur;
    int ups[$];
    int dns[$];
    cur = int'(car_pos);
    if (mask[cur]) begin
      exp_floor_q.push_back(2'(cur));
      exp_dur_q.push_back(dur);
    end
    for (int f = cur + 1; f < 3; f++) if (mask[f]) ups.push_back(f);
    for (int f = cur - 1; f >= 0; f--) if (mask[f]) dns.push_back(f);
    if (m_dir) begin
      foreach (ups[k]) begin exp_floor_q.push_back(2'(ups[k])); exp_dur_q.push_back(dur); end
      foreach (dns[k]) begin exp_floor_q.push_back(2'(dns[k])); exp_dur_q.push_back(dur); end
      if (dns.size() > 0) m_dir = 1'b0;
    end else begin
      foreach (dns[k]) begin exp_floor_q.push_back(2'(dns[k])); exp_dur_q.push_back(dur); end
      foreach (ups[k]) begin exp_floor_q.push_back(2'(ups[k])); exp_dur_q.push_back(dur); end
      if (ups.size() > 0) m_dir = 1'b1;
    end
  endtask

  // Drive a one-cycle call pulse; entered and left just after a posedge.
  task automatic pulse(input logic [2:0] m);
    call = m;
    @(posedge clk); #1;
    call = 3'b000;
  endtask

  task automatic wait_quiet(input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (!door_open && call_led == 3'b000 && !moving) stable++;
      else stable = 0;
    end
    chk({tag, "_settle"}, int'(stable >= 4), 1);
  endtask

  task automatic wait_door(input string tag);
    int n = 0;
    while (!door_open && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_door_seen"}, int'(door_open), 1);
  endtask

  task automatic run_episode(input logic [2:0] mask, input string tag);
    plan(mask, DWELL);
    pulse(mask);
    wait_quiet(tag);
    chk({tag, "_dir"}, int'(dir_up), int'(m_dir));
  endtask

  // Monitor: every door opening is checked against the scoreboard queue.
  int         mon_dur = 0;
  int         mon_exp_dur = DWELL;
  logic       mon_prev = 1'b0;
  always @(negedge clk) begin
    if (door_open && !mon_prev) begin
      mon_dur = 1;
      if (exp_floor_q.size() == 0) begin
        chk("unexpected_door", 1, 0);
        mon_exp_dur = DWELL;
      end else begin
        logic [1:0] f;
        f = exp_floor_q.pop_front();
        mon_exp_dur = exp_dur_q.pop_front();
        chk("door_floor", int'(cur_floor), int'(f));
      end
    end else if (door_open) begin
      mon_dur++;
    end
    if (door_open) chk("door_led_clear", int'(|(call_led & floor_onehot(cur_floor))), 0);
    if (!door_open && mon_prev) chk("door_len", mon_dur, mon_exp_dur);
    mon_prev = door_open;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] mask;
    logic [1:0] hold_pos;

    // 1: reset with all calls asserted
    reset = 1'b1;
    call  = 3'b111;
    m_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    call  = 3'b000;
    chk("rst_led", int'(call_led), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_goal", int'(goal_floor), int'(F1));
    chk("rst_dir", int'(dir_up), 1);
    @(posedge clk); #1;
    chk("rst_led_after", int'(call_led), 0);

    // 2: single call to F3 from idle at F1
    plan(3'b100, DWELL);
    pulse(3'b100);
    chk("t2_led", int'(call_led), 4);
    @(posedge clk); #1;
    chk("t2_goal", int'(goal_floor), int'(F3));
    wait_quiet("t2");
    chk("t2_dir", int'(dir_up), int'(m_dir));

    // 3: retarget to F2 while travelling F1->F3
    run_episode(3'b001, "t3pre");
    exp_floor_q.push_back(F2); exp_dur_q.push_back(DWELL);
    exp_floor_q.push_back(F3); exp_dur_q.push_back(DWELL);
    m_dir = 1'b1;
    pulse(3'b100);
    @(posedge clk); #1;
    chk("t3_goal_f3", int'(goal_floor), int'(F3));
    pulse(3'b010);
    chk("t3_led_110", int'(call_led), 6);
    @(posedge clk); #1;
    chk("t3_goal_f2", int'(goal_floor), int'(F2));
    wait_door("t3");
    chk("t3_led_100", int'(call_led), 4);
    wait_quiet("t3");
    chk("t3_dir", int'(dir_up), int'(m_dir));

    // 4: call at the open floor with timer=1 extends the dwell
    exp_floor_q.push_back(F2); exp_dur_q.push_back(DWELL + 3);
    m_dir = 1'b0;
    pulse(3'b010);
    wait_door("t4");
    @(posedge clk);
    @(posedge clk); #1;
    call = 3'b010;
    @(posedge clk); #1;
    call = 3'b000;
    chk("t4_led", int'(call_led), 0);
    chk("t4_door_held", int'(door_open), 1);
    wait_quiet("t4");
    chk("t4_dir", int'(dir_up), int'(m_dir));

    // 5: at F2 going down with F1 and F3 pending
    plan(3'b101, DWELL);
    pulse(3'b101);
    @(posedge clk); #1;
    chk("t5_goal_f1", int'(goal_floor), int'(F1));
    chk("t5_dir_dn", int'(dir_up), 0);
    wait_quiet("t5");
    chk("t5_dir", int'(dir_up), int'(m_dir));

    // 6: reset while travelling drops pending calls
    pulse(3'b011);
    chk("t6_led", int'(call_led), 3);
    @(posedge clk); #1;
    chk("t6_goal_f2", int'(goal_floor), int'(F2));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_dir = 1'b1;
    chk("t6_led_clr", int'(call_led), 0);
    chk("t6_door", int'(door_open), 0);
    chk("t6_goal", int'(goal_floor), int'(F1));
    chk("t6_dir", int'(dir_up), 1);
    wait_quiet("t6");

    // Randomized episodes, some issued while cur_floor reads invalid
    for (int e = 0; e < 24; e++) begin
      mask     = 3'($urandom_range(1, 7));
      step_len = $urandom_range(1, 6);
      if (e % 4 == 3) begin
        hold_pos = car_pos;
        force_invalid = 1'b1;
        pulse(mask);
        repeat (5) @(posedge clk);
        #1;
        chk("inv_goal_hold", int'(goal_floor), int'(hold_pos));
        chk("inv_door", int'(door_open), 0);
        chk("inv_led", int'(call_led), int'(mask));
        plan(mask, DWELL);
        force_invalid = 1'b0;
        wait_quiet("rnd_inv");
        chk("rnd_inv_dir", int'(dir_up), int'(m_dir));
      end else begin
        run_episode(mask, "rnd");
      end
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_floor_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
